// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR code averager
package sar_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      ACCUM = 2'd2
   } sar_state_t;

   localparam int CODE_W_DEF   = 5;
   localparam int OSR_LOG2_MIN = 0;
   localparam int OSR_LOG2_MAX = 4;

   // Sample counter needs at least one bit even when averaging a single code
   function automatic int cnt_width(input int osr_log2);
      return (osr_log2 > 1) ? osr_log2 : 1;
   endfunction

endpackage

// File: rtl/sar_avg_acc.sv
// rtl/sar_avg_acc.sv - accumulator, sample counter, rounding and result-pending strobe
// Rounding to nearest when SAR_AVG_ROUND_EN is defined, truncation otherwise.
module sar_avg_acc
   import sar_pkg::*;
#(
   parameter int CODE_W   = CODE_W_DEF,
   parameter int OSR_LOG2 = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clear,
   input  logic              sample,
   input  logic [CODE_W-1:0] code,
   output logic [CODE_W-1:0] result,
   output logic              result_pend
);

   localparam int AW = CODE_W + OSR_LOG2;
   localparam int CW = cnt_width(OSR_LOG2);
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << OSR_LOG2) - 1);

   logic [AW-1:0] acc;
   logic [AW-1:0] acc_final;
   logic [AW-1:0] rsum;
   logic [CW-1:0] cnt;
   logic          last;

   assign acc_final = acc + AW'(code);
   assign last      = (cnt == CNT_LAST);

`ifdef SAR_AVG_ROUND_EN
   localparam int HS = (OSR_LOG2 > 0) ? OSR_LOG2 - 1 : 0;
   localparam logic [AW-1:0] HALF = (OSR_LOG2 > 0) ? (AW'(1) << HS) : '0;
   assign rsum = acc_final + HALF;
`else
   assign rsum = acc_final;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc         <= '0;
         cnt         <= '0;
         result      <= '0;
         result_pend <= 1'b0;
      end else begin
         result_pend <= 1'b0;
         if (clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (sample) begin
            // The last sample closes the window in the same edge it is added
            if (last) begin
               acc         <= '0;
               cnt         <= '0;
               result      <= CODE_W'(rsum >> OSR_LOG2);
               result_pend <= 1'b1;
            end else begin
               acc <= acc_final;
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sar_code_averager.sv
// rtl/sar_code_averager.sv - SAR start/capture FSM, eoc edge detect and valid/ready result port
// Optional build macro: SAR_AVG_ROUND_EN (round-to-nearest averaging).
module sar_code_averager
   import sar_pkg::*;
#(
   parameter int CODE_W   = CODE_W_DEF,
   parameter int OSR_LOG2 = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              eoc,
   input  logic [CODE_W-1:0] code,
   output logic              start,
   output logic [CODE_W-1:0] data_out,
   output logic              data_valid,
   input  logic              data_ready,
   output logic              overrun,
   output logic              busy
);

   sar_state_t        state, state_next;
   logic              eoc_q;
   logic              sample_ev;
   logic              take;
   logic              arm_entry;
   logic              acc_clear;
   logic [CODE_W-1:0] result;
   logic              result_pend;

   assign sample_ev = eoc & ~eoc_q;
   assign acc_clear = ~busy | ~enable;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         eoc_q <= 1'b0;
      end else begin
         state <= state_next;
         eoc_q <= eoc;
      end
   end

   // Dropping enable wins over a coincident sample event
   always_comb begin
      state_next = state;
      start      = 1'b0;
      busy       = 1'b0;
      take       = 1'b0;
      arm_entry  = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = ARM;
               arm_entry  = 1'b1;
            end
         end
         ARM: begin
            start = 1'b1;
            busy  = 1'b1;
            if (!enable) begin
               state_next = IDLE;
            end else if (sample_ev) begin
               take       = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            busy = 1'b1;
            if (!enable) begin
               state_next = IDLE;
            end else begin
               take = sample_ev;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   sar_avg_acc #(
      .CODE_W   (CODE_W),
      .OSR_LOG2 (OSR_LOG2)
   ) u_acc (
      .clock       (clock),
      .reset       (reset),
      .clear       (acc_clear),
      .sample      (take),
      .code        (code),
      .result      (result),
      .result_pend (result_pend)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (arm_entry) begin
            overrun <= 1'b0;
         end
         // A handshake on the load edge consumes the old result cleanly
         if (result_pend) begin
            data_out   <= result;
            data_valid <= 1'b1;
            if (data_valid && !data_ready) begin
               overrun <= 1'b1;
            end
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_sar_code_averager.sv
// tb/tb_sar_code_averager.sv - directed table-driven bench for sar_code_averager (OSR_LOG2=2 and 0)
module tb_sar_code_averager;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       eoc;
   logic [4:0] code;
   logic       data_ready;

   logic       start, data_valid, overrun, busy;
   logic [4:0] data_out;
   logic       start0, data_valid0, overrun0, busy0;
   logic [4:0] data_out0;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0][4:0] c;
      logic [4:0]      et;
      logic [4:0]      er;
   } vec_t;

   vec_t vecs[8];

   sar_code_averager #(.CODE_W(5), .OSR_LOG2(2)) u_dut (
      .clock      (clk),
      .reset      (rst_n),
      .enable     (enable),
      .eoc        (eoc),
      .code       (code),
      .start      (start),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .overrun    (overrun),
      .busy       (busy)
   );

   sar_code_averager #(.CODE_W(5), .OSR_LOG2(0)) u_dut0 (
      .clock      (clk),
      .reset      (rst_n),
      .enable     (enable),
      .eoc        (eoc),
      .code       (code),
      .start      (start0),
      .data_out   (data_out0),
      .data_valid (data_valid0),
      .data_ready (data_ready),
      .overrun    (overrun0),
      .busy       (busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pulse(input logic [4:0] c, input int hold);
      @(negedge clk);
      eoc  = 1'b1;
      code = c;
      repeat (hold) @(negedge clk);
      eoc  = 1'b0;
   endtask

   function automatic vec_t mk(input logic [4:0] a, b, c, d, et, er);
      vec_t v;
      v.c  = {d, c, b, a};
      v.et = et;
      v.er = er;
      return v;
   endfunction

   function automatic logic [4:0] pick(input logic [4:0] et, input logic [4:0] er);
`ifdef SAR_AVG_ROUND_EN
      return er;
`else
      return et;
`endif
   endfunction

   initial begin
      vecs[0] = mk(5'd3,  5'd4,  5'd5,  5'd6,  5'd4,  5'd5);
      vecs[1] = mk(5'd31, 5'd31, 5'd31, 5'd31, 5'd31, 5'd31);
      vecs[2] = mk(5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0);
      vecs[3] = mk(5'd17, 5'd17, 5'd17, 5'd17, 5'd17, 5'd17);
      vecs[4] = mk(5'd1,  5'd2,  5'd2,  5'd2,  5'd1,  5'd2);
      vecs[5] = mk(5'd10, 5'd11, 5'd12, 5'd13, 5'd11, 5'd12);
      vecs[6] = mk(5'd30, 5'd31, 5'd31, 5'd31, 5'd30, 5'd31);
      vecs[7] = mk(5'd8,  5'd8,  5'd8,  5'd8,  5'd8,  5'd8);

      rst_n      = 1'b0;
      enable     = 1'b0;
      eoc        = 1'b0;
      code       = '0;
      data_ready = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_data_out", data_out, 0);
      chk("rst_data_valid", data_valid, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data_valid0", data_valid0, 0);

      rst_n  = 1'b1;
      enable = 1'b1;
      chk("arm_start_before", start, 0);
      @(negedge clk);
      chk("arm_start", start, 1);
      chk("arm_busy", busy, 1);

      // Table: four codes per average, result one clock after the 4th capture
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) begin
            pulse(vecs[i].c[k], 1);
            if (i == 0 && k == 0) begin
               chk("first_eoc_start", start, 0);
               chk("first_eoc_busy", busy, 1);
            end
         end
         chk($sformatf("vec%0d_latency", i), data_valid, 0);
         @(negedge clk);
         chk($sformatf("vec%0d_valid", i), data_valid, 1);
         chk($sformatf("vec%0d_data", i), data_out, pick(vecs[i].et, vecs[i].er));
         chk($sformatf("vec%0d_osr0", i), data_out0, vecs[i].c[3]);
      end

      // Held eoc: each 3-clock pulse counts once
      pulse(5'd2, 3);
      pulse(5'd4, 3);
      pulse(5'd6, 3);
      data_ready = 1'b0;
      pulse(5'd8, 3);
      chk("held_valid", data_valid, 1);
      chk("held_data", data_out, 5);
      chk("held_osr0", data_out0, 8);
      data_ready = 1'b1;
      @(negedge clk);
      chk("held_consumed", data_valid, 0);
      chk("held_data_hold", data_out, 5);

      // Overrun: two results with no consumer
      data_ready = 1'b0;
      for (int k = 0; k < 4; k++) pulse(5'd1, 1);
      @(negedge clk);
      chk("ovr_first_data", data_out, 1);
      chk("ovr_first_flag", overrun, 0);
      for (int k = 0; k < 4; k++) pulse(5'd9, 1);
      @(negedge clk);
      chk("ovr_second_data", data_out, 9);
      chk("ovr_second_valid", data_valid, 1);
      chk("ovr_flag", overrun, 1);

      // Abort after two samples, pending result must survive
      pulse(5'd20, 1);
      pulse(5'd20, 1);
      enable = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_start", start, 0);
      chk("abort_pending_valid", data_valid, 1);
      chk("abort_pending_data", data_out, 9);
      chk("abort_overrun_kept", overrun, 1);
      enable     = 1'b1;
      data_ready = 1'b1;
      @(negedge clk);
      chk("reenable_overrun", overrun, 0);
      chk("reenable_start", start, 1);
      for (int k = 0; k < 4; k++) pulse(5'd8, 1);
      @(negedge clk);
      chk("reenable_data", data_out, 8);
      chk("reenable_valid", data_valid, 1);
      @(negedge clk);

      // Handshake on the same edge as the next load
      data_ready = 1'b0;
      for (int k = 0; k < 4; k++) pulse(5'd5, 1);
      for (int k = 0; k < 4; k++) pulse(5'd6, 1);
      data_ready = 1'b1;
      @(negedge clk);
      chk("same_edge_overrun", overrun, 0);
      chk("same_edge_data", data_out, 6);
      chk("same_edge_valid", data_valid, 1);
      @(negedge clk);
      chk("hs_valid_low", data_valid, 0);
      chk("hs_data_hold", data_out, 6);

      // Asynchronous reset mid-average with a result pending
      data_ready = 1'b0;
      for (int k = 0; k < 4; k++) pulse(5'd7, 1);
      pulse(5'd3, 1);
      pulse(5'd3, 1);
      @(negedge clk);
      chk("pre_async_valid", data_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_start", start, 0);
      chk("async_valid", data_valid, 0);
      chk("async_data", data_out, 0);
      chk("async_overrun", overrun, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
